// File: rtl/vhd_pkg.sv
// Purpose : shared types and constants for the virtual-disk sector controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package vhd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } vhd_state_e;

    // True when the requested sector lies inside the mounted image.
    // Sector count is the image size in bytes with the low 9 bits dropped.
    function automatic logic lba_in_range(input logic [31:0] lba,
                                          input logic [31:0] sectors);
        return lba < sectors;
    endfunction

endpackage

// File: rtl/vhd_sector_ram.sv
// Purpose : 512x8 true dual-port sector buffer; port A = host, port B = HPS.
// Latency : synchronous read, data one cycle after the address; read-before-write.
// Backpressure: none, both ports accept an access every cycle.
// Ports   : clk_sys; a_addr/a_wdata/a_we/a_rdata (host); b_addr/b_wdata/b_we/b_rdata (HPS).
module vhd_sector_ram
    import vhd_pkg::*;
(
    input  logic                 clk_sys,
    input  logic [SECTOR_AW-1:0] a_addr,
    input  logic [7:0]           a_wdata,
    input  logic                 a_we,
    output logic [7:0]           a_rdata,
    input  logic [SECTOR_AW-1:0] b_addr,
    input  logic [7:0]           b_wdata,
    input  logic                 b_we,
    output logic [7:0]           b_rdata
);

    logic [7:0] mem [SECTOR_BYTES];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    // Contents are intentionally not reset. The controller never lets both
    // ports write in the same cycle (host writes only while idle, HPS only
    // during a read transfer), so one process owning the array is safe.
    always_ff @(posedge clk_sys) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        a_rdata_q <= mem[a_addr];
        b_rdata_q <= mem[b_addr];
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/vhd_sector_ctrl.sv
// Purpose : one-sector virtual-disk transfer controller between a host and the HPS.
// Latency : request accepted -> sd_rd/sd_wr next cycle; done one cycle after sd_ack falls.
// Backpressure: host requests while busy are silently ignored; host buffer writes dropped while busy.
// Ports   : img_mounted/img_size (mount), req_rd/req_wr/req_lba + busy/done/err/present (host control),
//           host_addr/host_wdata/host_we/host_rdata (host buffer),
//           sd_rd/sd_wr/sd_lba/sd_ack/sd_buff_* (HPS side).
module vhd_sector_ctrl
    import vhd_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 img_mounted,
    input  logic [63:0]          img_size,
    input  logic                 req_rd,
    input  logic                 req_wr,
    input  logic [31:0]          req_lba,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 present,
    input  logic [SECTOR_AW-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    input  logic                 host_we,
    output logic [7:0]           host_rdata,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [31:0]          sd_lba,
    input  logic                 sd_ack,
    input  logic [SECTOR_AW-1:0] sd_buff_addr,
    input  logic [7:0]           sd_buff_dout,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din
);

    vhd_state_e  state_q, state_d;
    logic        rd_dir_q, rd_dir_d;    // 1 = read from image into buffer
    logic [31:0] sd_lba_q, sd_lba_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        present_q, present_d;
    logic        ack_q, ack_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] cnt_inc;
    logic        req_any;
    logic        req_ok;
    logic        ram_a_we;
    logic        ram_b_we;

    always_comb begin
        state_d   = state_q;
        rd_dir_d  = rd_dir_q;
        sd_lba_d  = sd_lba_q;
        sd_rd_d   = 1'b0;
        sd_wr_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        ack_d     = sd_ack;
        // A remount takes effect immediately but never disturbs a transfer.
        present_d = img_mounted ? (|img_size) : present_q;
        // Saturating increment so a huge ACK_TIMEOUT cannot wrap the counter.
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
        req_any   = req_rd | req_wr;
        req_ok    = (req_rd ^ req_wr) & present_q &
                    lba_in_range(req_lba, img_size[40:9]);

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    state_d  = ST_REQ;
                    sd_lba_d = req_lba;
                    rd_dir_d = req_rd;
                    sd_rd_d  = req_rd;
                    sd_wr_d  = req_wr;
                    cnt_d    = '0;
                end else if (req_any) begin
                    err_d = 1'b1;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (sd_ack) begin
                    state_d = ST_XFER;
                end else if (cnt_inc >= ACK_TIMEOUT) begin
                    // The cycle that would make the count reach the limit
                    // is the last one the request line is held.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    sd_rd_d = rd_dir_q;
                    sd_wr_d = ~rd_dir_q;
                end
            end
            ST_XFER: begin
                if (ack_q && !sd_ack) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_dir_q  <= 1'b0;
            sd_lba_q  <= '0;
            sd_rd_q   <= 1'b0;
            sd_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            present_q <= 1'b0;
            ack_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_dir_q  <= rd_dir_d;
            sd_lba_q  <= sd_lba_d;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            present_q <= present_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign present = present_q;
    assign sd_rd   = sd_rd_q;
    assign sd_wr   = sd_wr_q;
    assign sd_lba  = sd_lba_q;

    // Host may only touch the buffer while idle; HPS may only fill it during
    // the data phase of a read.
    assign ram_a_we = host_we & ~busy;
    assign ram_b_we = sd_buff_wr & (state_q == ST_XFER) & rd_dir_q;

    vhd_sector_ram u_ram (
        .clk_sys (clk_sys),
        .a_addr  (host_addr),
        .a_wdata (host_wdata),
        .a_we    (ram_a_we),
        .a_rdata (host_rdata),
        .b_addr  (sd_buff_addr),
        .b_wdata (sd_buff_dout),
        .b_we    (ram_b_we),
        .b_rdata (sd_buff_din)
    );

endmodule

// File: tb/tb_vhd_sector_ctrl.sv
// Purpose : self-checking bench for vhd_sector_ctrl with a buffer/mount model and directed transfers.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_vhd_sector_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        img_mounted;
    logic [63:0] img_size;
    logic        req_rd, req_wr;
    logic [31:0] req_lba;
    logic        busy, done, err, present;
    logic [8:0]  host_addr;
    logic [7:0]  host_wdata;
    logic        host_we;
    logic [7:0]  host_rdata;
    logic        sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    always #5 clk_sys = ~clk_sys;

    vhd_sector_ctrl #(.ACK_TIMEOUT(24'd16)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .present      (present),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_we      (host_we),
        .host_rdata   (host_rdata),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_lba       (sd_lba),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    int n_chk = 0;
    int n_err = 0;
    int c_done, c_err, c_rd, c_wr;
    bit chk_en;
    bit host_we_drop;   // bench intends this host write to land while busy
    bit buff_wr_drop;   // bench intends this HPS write to land outside a read transfer

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clr();
        c_done = 0;
        c_err  = 0;
        c_rd   = 0;
        c_wr   = 0;
    endtask

    // Behavioural model: byte array buffer with read-before-write ports,
    // plus the mount flag. Which writes count is decided by the bench's
    // own knowledge of when a transfer is in progress.
    logic [7:0] mdl_mem [512];
    logic [7:0] exp_host, exp_din;
    logic       mdl_present;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mdl_present <= 1'b0;
        end else begin
            exp_host <= mdl_mem[host_addr];
            exp_din  <= mdl_mem[sd_buff_addr];
            if (host_we && !host_we_drop)
                mdl_mem[host_addr] <= host_wdata;
            if (sd_buff_wr && !buff_wr_drop)
                mdl_mem[sd_buff_addr] <= sd_buff_dout;
            if (img_mounted)
                mdl_present <= |img_size;
        end
    end

    // Pulse/level counters sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            c_done = c_done + int'(done);
            c_err  = c_err + int'(err);
            c_rd   = c_rd + int'(sd_rd);
            c_wr   = c_wr + int'(sd_wr);
        end
    end

    // Per-cycle comparison against the model and protocol invariants.
    always @(negedge clk_sys) begin
        if (chk_en && reset_n) begin
            check("host_rdata_model", host_rdata, exp_host);
            check("sd_buff_din_model", sd_buff_din, exp_din);
            check("present_model", present, mdl_present);
            check("rd_wr_exclusive", sd_rd & sd_wr, 0);
            check("idle_no_request", ~busy & (sd_rd | sd_wr), 0);
            check("done_err_exclusive", done & err, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; img_mounted = 1'b0; img_size = '0;
        req_rd = 1'b0; req_wr = 1'b0; req_lba = '0;
        host_addr = '0; host_wdata = '0; host_we = 1'b0;
        sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        chk_en = 1'b0; host_we_drop = 1'b0; buff_wr_drop = 1'b0;
        clr();

        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_present", present, 0);
        check("rst_sd_rd", sd_rd, 0);
        check("rst_sd_wr", sd_wr, 0);
        check("rst_sd_lba", sd_lba, 0);
        #2 reset_n = 1'b1;
        tick();

        // Fill the whole buffer so every later read has a known value.
        for (int a = 0; a < 512; a++) begin
            host_we = 1'b1; host_addr = a[8:0]; host_wdata = a[7:0] ^ 8'h3C;
            tick();
        end
        host_we = 1'b0;
        tick();
        chk_en = 1'b1;

        // Mount a 1 MiB image: 2048 sectors.
        img_size = 64'd1_048_576; img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        check("mount_present", present, 1);

        // Read sector 5; ack after 3 cycles, HPS fills addr[7:0].
        clr();
        req_rd = 1'b1; req_lba = 32'd5;
        tick();
        req_rd = 1'b0;
        check("rd_sd_rd_high", sd_rd, 1);
        check("rd_busy", busy, 1);
        check("rd_sd_lba", sd_lba, 5);
        tick();
        tick();
        sd_ack = 1'b1;
        tick();
        check("rd_sd_rd_drop", sd_rd, 0);
        for (int a = 0; a < 512; a++) begin
            sd_buff_wr = 1'b1; sd_buff_addr = a[8:0]; sd_buff_dout = a[7:0];
            tick();
        end
        sd_buff_wr = 1'b0;
        host_we_drop = 1'b1; host_we = 1'b1; host_addr = 9'h1FF; host_wdata = 8'h00;
        tick();
        host_we = 1'b0; host_we_drop = 1'b0;
        check("rd_lba_stable", sd_lba, 5);
        sd_ack = 1'b0;
        tick();
        check("rd_done_pulse", done, 1);
        check("rd_busy_in_done", busy, 1);
        tick();
        check("rd_done_clear", done, 0);
        check("rd_idle", busy, 0);
        tick();
        check("rd_sd_rd_cycles", c_rd, 3);
        check("rd_done_count", c_done, 1);
        check("rd_err_count", c_err, 0);
        host_addr = 9'h1FF;
        tick();
        check("rd_host_1ff", host_rdata, 8'hFF);
        host_addr = 9'h080;
        tick();
        check("rd_host_080", host_rdata, 8'h80);

        // Write sector 0 after host stores 0xA5 at 0x010; remount mid-transfer.
        clr();
        host_we = 1'b1; host_addr = 9'h010; host_wdata = 8'hA5;
        tick();
        host_we = 1'b0;
        req_wr = 1'b1; req_lba = 32'd0;
        tick();
        req_wr = 1'b0;
        check("wr_sd_wr_high", sd_wr, 1);
        check("wr_sd_lba", sd_lba, 0);
        sd_ack = 1'b1;
        tick();
        check("wr_sd_wr_drop", sd_wr, 0);
        img_mounted = 1'b1; sd_buff_addr = 9'h010;
        tick();
        img_mounted = 1'b0;
        check("wr_din_a5", sd_buff_din, 8'hA5);
        check("wr_mount_no_abort", busy, 1);
        buff_wr_drop = 1'b1; sd_buff_wr = 1'b1; sd_buff_dout = 8'h00;
        tick();
        sd_buff_wr = 1'b0; buff_wr_drop = 1'b0;
        tick();
        check("wr_buff_wr_ignored", sd_buff_din, 8'hA5);
        sd_ack = 1'b0;
        tick();
        check("wr_done_pulse", done, 1);
        tick();
        tick();
        check("wr_sd_wr_cycles", c_wr, 1);
        check("wr_done_count", c_done, 1);
        check("wr_err_count", c_err, 0);

        // Out-of-range LBA, then the last valid sector.
        clr();
        req_rd = 1'b1; req_lba = 32'd2048;
        tick();
        req_rd = 1'b0;
        check("oor_err", err, 1);
        check("oor_busy", busy, 0);
        check("oor_sd_rd", sd_rd, 0);
        tick();
        check("oor_err_clear", err, 0);
        req_rd = 1'b1; req_lba = 32'd2047;
        tick();
        req_rd = 1'b0;
        check("max_lba_accept", sd_rd, 1);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
        check("max_lba_idle", busy, 0);
        check("oor_err_count", c_err, 1);
        check("max_lba_done_count", c_done, 1);

        // Ack timeout with ACK_TIMEOUT = 16.
        clr();
        req_rd = 1'b1; req_lba = 32'd1;
        tick();
        req_rd = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        tick();
        check("to_idle", busy, 0);
        check("to_sd_rd_cycles", c_rd, 16);
        check("to_err_count", c_err, 1);
        check("to_done_count", c_done, 0);

        // Both strobes together, then a strobe while busy.
        clr();
        req_rd = 1'b1; req_wr = 1'b1; req_lba = 32'd3;
        tick();
        req_rd = 1'b0; req_wr = 1'b0;
        check("both_err", err, 1);
        check("both_busy", busy, 0);
        check("both_no_req", sd_rd | sd_wr, 0);
        tick();
        req_rd = 1'b1; req_lba = 32'd4;
        tick();
        check("busy_accept", busy, 1);
        req_lba = 32'd7;
        tick();
        req_rd = 1'b0;
        check("busy_req_no_err", err, 0);
        check("busy_req_lba_kept", sd_lba, 4);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        repeat (4) tick();
        check("busy_req_idle", busy, 0);
        check("busy_req_err_count", c_err, 1);
        check("busy_req_done_count", c_done, 1);
        check("busy_req_sd_rd_cycles", c_rd, 2);

        // Reset asserted during the data phase of a read.
        clr();
        req_rd = 1'b1; req_lba = 32'd6;
        tick();
        req_rd = 1'b0;
        sd_ack = 1'b1;
        tick();
        check("rst_xfer_busy_before", busy, 1);
        #2;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_async_sd_rd", sd_rd, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_present", present, 0);
        check("rst_async_lba", sd_lba, 0);
        sd_ack = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b1;
        clr();
        tick();
        chk_en = 1'b1;
        repeat (5) tick();
        check("rst_no_done", c_done, 0);
        check("rst_no_err", c_err, 0);
        check("rst_idle", busy, 0);
        host_addr = 9'h1FF;
        tick();
        check("rst_buffer_kept", host_rdata, 8'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
